// File: rtl/st_align_buf.sv
// rtl/st_align_buf.sv - store-path write aligner: 2-entry request FIFO feeding lane-shifted, possibly split, memory write beats
module st_align_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        req_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_sel,
  output logic        empty
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q [2];
  logic [31:0] data_q [2];
  logic [1:0]  size_q [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count, count_next;
  logic        err_q;

  logic        accept, push, pop;
  logic [31:0] masked_data;
  logic [31:0] head_addr, head_data, word_addr;
  logic [1:0]  head_size, k;
  logic [3:0]  base_sel;
  logic [63:0] wide_data;
  logic [7:0]  wide_sel;
  logic        has_beat1;

  assign req_ready = (count != 2'd2);
  assign accept    = req_valid && req_ready;
  assign push      = accept && (req_size != 2'b11);
  assign req_err   = err_q;

  always_comb begin
    masked_data = 32'd0;
    case (req_size)
      2'b00:   masked_data = {24'd0, req_data[7:0]};
      2'b01:   masked_data = {16'd0, req_data[15:0]};
      default: masked_data = req_data;
    endcase
  end

  // Alignment of the head entry: data and selects shifted into a two-word window.
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign head_size = size_q[rd_ptr];
  assign k         = head_addr[1:0];
  assign word_addr = {head_addr[31:2], 2'b00};

  always_comb begin
    base_sel = 4'b0000;
    case (head_size)
      2'b00:   base_sel = 4'b0001;
      2'b01:   base_sel = 4'b0011;
      default: base_sel = 4'b1111;
    endcase
  end

  assign wide_data = {32'd0, head_data} << {k, 3'b000};
  assign wide_sel  = {4'b0000, base_sel} << k;
  assign has_beat1 = |wide_sel[7:4];

  assign pop = mem_ready && ((state == BEAT0 && !has_beat1) || state == BEAT1);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      err_q     <= 1'b0;
      addr_q[0] <= 32'd0;
      addr_q[1] <= 32'd0;
      data_q[0] <= 32'd0;
      data_q[1] <= 32'd0;
      size_q[0] <= 2'b00;
      size_q[1] <= 2'b00;
    end else begin
      state <= state_next;
      count <= count_next;
      err_q <= accept && (req_size == 2'b11);
      if (push) begin
        addr_q[wr_ptr] <= req_addr;
        data_q[wr_ptr] <= masked_data;
        size_q[wr_ptr] <= req_size;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count_next != 2'd0) state_next = BEAT0;
      BEAT0:   if (mem_ready) begin
                 if (has_beat1)               state_next = BEAT1;
                 else if (count_next != 2'd0) state_next = BEAT0;
                 else                         state_next = IDLE;
               end
      BEAT1:   if (mem_ready) state_next = (count_next != 2'd0) ? BEAT0 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are zero in IDLE so a reset leaves the memory port quiet.
  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_sel   = 4'b0000;
    empty     = (count == 2'd0) && (state == IDLE);
    case (state)
      BEAT0: begin
        mem_valid = 1'b1;
        mem_addr  = word_addr;
        mem_wdata = wide_data[31:0];
        mem_sel   = wide_sel[3:0];
      end
      BEAT1: begin
        mem_valid = 1'b1;
        mem_addr  = word_addr + 32'd4;
        mem_wdata = wide_data[63:32];
        mem_sel   = wide_sel[7:4];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_st_align_buf.sv
// tb/tb_st_align_buf.sv - randomized bench for st_align_buf against a byte-level store model
module tb_st_align_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_data = 32'd0;
  logic [1:0]  req_size = 2'b00;
  logic        req_err;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic        empty;

  st_align_buf dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size), .req_err(req_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_sel(mem_sel), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        last;
  } beat_t;

  beat_t beats[$];
  int    pend_reqs = 0;
  logic  err_exp = 1'b0;
  logic  after_reset = 1'b0;
  int    n_checks = 0;
  int    n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  // Expected beats built byte by byte: every stored byte lands in the word containing its address.
  function automatic void model_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    logic [31:0] base, ba, w0, w1;
    logic [3:0]  s0, s1;
    beat_t       b;
    int          nbytes;
    base = addr & 32'hFFFF_FFFC;
    w0 = 0; w1 = 0; s0 = 0; s1 = 0;
    nbytes = 1 << size;
    for (int i = 0; i < nbytes; i++) begin
      ba = addr + i;
      if ((ba & 32'hFFFF_FFFC) == base) begin
        w0 |= 32'(data[8*i +: 8]) << (8 * ba[1:0]);
        s0 |= 4'(1 << ba[1:0]);
      end else begin
        w1 |= 32'(data[8*i +: 8]) << (8 * ba[1:0]);
        s1 |= 4'(1 << ba[1:0]);
      end
    end
    b.addr = base; b.wdata = w0; b.sel = s0; b.last = (s1 == 0);
    beats.push_back(b);
    if (s1 != 0) begin
      b.addr = base + 32'd4; b.wdata = w1; b.sel = s1; b.last = 1'b1;
      beats.push_back(b);
    end
  endfunction

  // One clock: check outputs at the negedge, drive inputs, then advance the model for the coming edge.
  task automatic cycle(input logic rv, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic mr, input logic rst);
    beat_t b;
    check("req_ready", 32'(req_ready), 32'(pend_reqs != 2));
    check("mem_valid", 32'(mem_valid), 32'(pend_reqs != 0));
    check("empty", 32'(empty), 32'(pend_reqs == 0));
    check("req_err", 32'(req_err), 32'(err_exp));
    if (after_reset) begin
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_mem_sel", 32'(mem_sel), 32'd0);
    end
    if (pend_reqs != 0 && beats.size() != 0) begin
      check("mem_addr", mem_addr, beats[0].addr);
      check("mem_wdata", mem_wdata, beats[0].wdata);
      check("mem_sel", 32'(mem_sel), 32'(beats[0].sel));
    end
    req_valid = rv; req_addr = a; req_data = d; req_size = sz; mem_ready = mr; rst_n = ~rst;
    #1;
    if (rst) begin
      beats.delete();
      pend_reqs = 0;
      err_exp = 1'b0;
      after_reset = 1'b1;
    end else begin
      after_reset = 1'b0;
      if (pend_reqs != 0 && mr && beats.size() != 0) begin
        b = beats.pop_front();
        if (b.last) pend_reqs--;
      end
      err_exp = rv && (pend_reqs_before_ok(rv)) && (sz == 2'b11);
      if (rv && req_ready && sz != 2'b11) begin
        model_store(a, d, sz);
        pend_reqs++;
      end
    end
    @(negedge clk);
  endtask

  // Acceptance is judged from the model's pre-edge occupancy, not from the DUT.
  int pend_at_drive;
  function automatic logic pend_reqs_before_ok(input logic rv);
    return rv && (pend_at_drive != 2);
  endfunction

  task automatic step(input logic rv, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic mr);
    pend_at_drive = pend_reqs;
    cycle(rv, a, d, sz, mr, 1'b0);
  endtask

  task automatic idle(input int n, input logic mr);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 2'b00, mr);
  endtask

  task automatic do_reset();
    pend_at_drive = pend_reqs;
    cycle(1'b0, 32'd0, 32'd0, 2'b00, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rs;
    @(negedge clk);
    pend_at_drive = 0;
    do_reset();
    do_reset();
    idle(1, 1'b1);

    step(1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b1);
    idle(2, 1'b1);
    step(1'b1, 32'h203, 32'h123456AB, 2'b00, 1'b1);
    step(1'b1, 32'h202, 32'hFFFFCAFE, 2'b01, 1'b1);
    idle(3, 1'b1);
    step(1'b1, 32'h101, 32'h11223344, 2'b10, 1'b1);
    idle(3, 1'b1);
    step(1'b1, 32'hFFFFFFFF, 32'h0000BBAA, 2'b01, 1'b1);
    idle(3, 1'b1);

    step(1'b1, 32'h300, 32'hAAAA0000, 2'b11, 1'b1);
    idle(2, 1'b1);

    step(1'b1, 32'h400, 32'h01020304, 2'b10, 1'b0);
    step(1'b1, 32'h405, 32'h0000A5A5, 2'b01, 1'b0);
    step(1'b1, 32'h40A, 32'hCCDDEEFF, 2'b10, 1'b0);
    idle(3, 1'b0);
    idle(6, 1'b1);

    step(1'b1, 32'h503, 32'h55667788, 2'b10, 1'b1);
    idle(1, 1'b1);
    do_reset();
    idle(2, 1'b1);

    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 9) == 0) ra = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
      rs = 2'($urandom_range(0, 3));
      if (rs == 2'b11 && $urandom_range(0, 2) != 0) rs = 2'b10;
      if ($urandom_range(0, 99) == 0) do_reset();
      else step($urandom_range(0, 9) < 7, ra, $urandom, rs, $urandom_range(0, 9) < 6);
    end
    idle(8, 1'b1);
    check("drained", 32'(beats.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
